// File: rtl/rinv_collector.sv
// Reader end of the R-inverse element stream: requests the 9 row-major Q4.12
// elements of a 3x3 matrix, keeps the upper triangle and offers it downstream.
module rinv_collector #(
  parameter int SIZE   = 16,
  parameter int N_ELEM = 9   // 3x3 row-major; the slot map below assumes this
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   Rinv_Mat_DnLoad,
  input  logic                   Rinv_Finish,
  input  logic        [SIZE-1:0] R_invElem,
  input  logic                   pause,
  output logic                   Rinv_Read,
  output logic signed [SIZE-1:0] Rinv_00,
  output logic signed [SIZE-1:0] Rinv_01,
  output logic signed [SIZE-1:0] Rinv_02,
  output logic signed [SIZE-1:0] Rinv_11,
  output logic signed [SIZE-1:0] Rinv_12,
  output logic signed [SIZE-1:0] Rinv_22,
  output logic                   mat_valid,
  input  logic                   mat_ready,
  output logic                   struct_err,
  output logic                   seq_err,
  output logic                   ovr_err
);

  localparam int CNT_W = $clog2(N_ELEM + 1);

  localparam logic [CNT_W-1:0] SLOT_00   = CNT_W'(0);
  localparam logic [CNT_W-1:0] SLOT_01   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SLOT_02   = CNT_W'(2);
  localparam logic [CNT_W-1:0] SLOT_10   = CNT_W'(3);
  localparam logic [CNT_W-1:0] SLOT_11   = CNT_W'(4);
  localparam logic [CNT_W-1:0] SLOT_12   = CNT_W'(5);
  localparam logic [CNT_W-1:0] SLOT_20   = CNT_W'(6);
  localparam logic [CNT_W-1:0] SLOT_21   = CNT_W'(7);
  localparam logic [CNT_W-1:0] SLOT_22   = CNT_W'(8);
  localparam logic [CNT_W-1:0] NUM_ELEMS = CNT_W'(N_ELEM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dnload_q;
  logic             r_rd_q;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_cap_cnt;
  logic             r_struct_err;
  logic             r_seq_err;
  logic             r_ovr_err;

  logic signed [SIZE-1:0] r_e00;
  logic signed [SIZE-1:0] r_e01;
  logic signed [SIZE-1:0] r_e02;
  logic signed [SIZE-1:0] r_e11;
  logic signed [SIZE-1:0] r_e12;
  logic signed [SIZE-1:0] r_e22;

  logic w_rise;
  logic w_read;
  logic w_mat_valid;
  logic w_capture;
  logic w_last_cap;

  // Lower-triangle positions are checked for zero but never stored.
  function automatic logic is_lower_slot(input logic [CNT_W-1:0] slot);
    return (slot == SLOT_10) || (slot == SLOT_20) || (slot == SLOT_21);
  endfunction

  assign w_rise     = Rinv_Mat_DnLoad & ~r_dnload_q;
  assign w_capture  = (r_state == ST_READ) & r_rd_q;
  assign w_last_cap = w_capture & (r_cap_cnt == SLOT_22);

  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_mat_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_read = ~pause & (r_req_cnt < NUM_ELEMS);
        if (w_last_cap) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_mat_valid = 1'b1;
        if (mat_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (start) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request/capture counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dnload_q   <= 1'b0;
      r_rd_q       <= 1'b0;
      r_req_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_struct_err <= 1'b0;
      r_seq_err    <= 1'b0;
      r_ovr_err    <= 1'b0;
    end else begin
      r_dnload_q <= Rinv_Mat_DnLoad;
      if (start) begin
        r_rd_q       <= 1'b0;
        r_req_cnt    <= '0;
        r_cap_cnt    <= '0;
        r_struct_err <= 1'b0;
        r_seq_err    <= 1'b0;
        r_ovr_err    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_rd_q <= 1'b0;
            if (w_rise) begin
              r_req_cnt <= '0;
              r_cap_cnt <= '0;
            end
          end
          ST_READ: begin
            r_rd_q <= w_read;
            if (w_read) r_req_cnt <= r_req_cnt + 1'b1;
            if (r_rd_q) begin
              r_cap_cnt <= r_cap_cnt + 1'b1;
              if (is_lower_slot(r_cap_cnt) && (R_invElem != '0)) r_struct_err <= 1'b1;
              // Finish must rise exactly with the last element, not before.
              if ((r_cap_cnt != SLOT_22) && Rinv_Finish)  r_seq_err <= 1'b1;
              if ((r_cap_cnt == SLOT_22) && !Rinv_Finish) r_seq_err <= 1'b1;
            end
          end
          ST_HOLD: begin
            r_rd_q <= 1'b0;
            if (w_rise) r_ovr_err <= 1'b1;
          end
          default: r_rd_q <= 1'b0;
        endcase
      end
    end
  end

  // Element capture; start leaves the last delivered matrix on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e00 <= '0;
      r_e01 <= '0;
      r_e02 <= '0;
      r_e11 <= '0;
      r_e12 <= '0;
      r_e22 <= '0;
    end else if (!start && w_capture) begin
      case (r_cap_cnt)
        SLOT_00: r_e00 <= R_invElem;
        SLOT_01: r_e01 <= R_invElem;
        SLOT_02: r_e02 <= R_invElem;
        SLOT_11: r_e11 <= R_invElem;
        SLOT_12: r_e12 <= R_invElem;
        SLOT_22: r_e22 <= R_invElem;
        default: ;
      endcase
    end
  end

  assign Rinv_Read  = w_read;
  assign mat_valid  = w_mat_valid;
  assign Rinv_00    = r_e00;
  assign Rinv_01    = r_e01;
  assign Rinv_02    = r_e02;
  assign Rinv_11    = r_e11;
  assign Rinv_12    = r_e12;
  assign Rinv_22    = r_e22;
  assign struct_err = r_struct_err;
  assign seq_err    = r_seq_err;
  assign ovr_err    = r_ovr_err;

endmodule

// File: tb/tb_rinv_collector.sv
// Bench for rinv_collector: directed matrices with literal expectations, then
// random traffic, all compared each cycle against a transaction-level model.
module tb_rinv_collector;

  localparam int SIZE = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   Rinv_Mat_DnLoad;
  logic                   Rinv_Finish;
  logic        [SIZE-1:0] R_invElem;
  logic                   pause;
  logic                   Rinv_Read;
  logic signed [SIZE-1:0] Rinv_00, Rinv_01, Rinv_02, Rinv_11, Rinv_12, Rinv_22;
  logic                   mat_valid;
  logic                   mat_ready;
  logic                   struct_err, seq_err, ovr_err;

  always #5 clk = ~clk;

  rinv_collector #(.SIZE(SIZE), .N_ELEM(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Rinv_Mat_DnLoad(Rinv_Mat_DnLoad), .Rinv_Finish(Rinv_Finish),
    .R_invElem(R_invElem), .pause(pause), .Rinv_Read(Rinv_Read),
    .Rinv_00(Rinv_00), .Rinv_01(Rinv_01), .Rinv_02(Rinv_02),
    .Rinv_11(Rinv_11), .Rinv_12(Rinv_12), .Rinv_22(Rinv_22),
    .mat_valid(mat_valid), .mat_ready(mat_ready),
    .struct_err(struct_err), .seq_err(seq_err), .ovr_err(ovr_err)
  );

  int n_cmp;
  int n_fail;

  // Model: mode 0 idle, 1 collecting, 2 offering a matrix.
  int          m_mode;
  int          m_issued;
  int          m_got;
  bit          m_inflight;
  bit          m_dq;
  logic [15:0] m_out [9];
  bit          m_serr, m_qerr, m_oerr;

  // Producer
  logic [15:0] stream [9];
  int          fin_at;
  int          pidx;
  bit          prev_rd;
  bit          rnd_mode;

  // Per-matrix observations
  int r_nrd, r_first, r_last, r_vc, r_rdp, r_s10;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_issued = 0; m_got = 0; m_inflight = 0; m_dq = 0;
    m_serr = 0; m_qerr = 0; m_oerr = 0;
    for (int i = 0; i < 9; i++) m_out[i] = 16'h0;
  endtask

  task automatic model_step();
    bit rise, rd;
    rise = Rinv_Mat_DnLoad && !m_dq;
    if (start) begin
      m_mode = 0; m_issued = 0; m_got = 0; m_inflight = 0;
      m_serr = 0; m_qerr = 0; m_oerr = 0;
    end else if (m_mode == 1) begin
      rd = !pause && (m_issued < 9);
      if (m_inflight) begin
        if (m_got == 3 || m_got == 6 || m_got == 7) begin
          if (R_invElem != 16'h0) m_serr = 1;
        end else begin
          m_out[m_got] = R_invElem;
        end
        if (m_got < 8 && Rinv_Finish)   m_qerr = 1;
        if (m_got == 8 && !Rinv_Finish) m_qerr = 1;
        m_got++;
        if (m_got == 9) m_mode = 2;
      end
      m_inflight = rd;
      if (rd) m_issued++;
    end else if (m_mode == 2) begin
      if (rise) m_oerr = 1;
      if (mat_ready) m_mode = 0;
    end else if (rise) begin
      m_mode = 1; m_issued = 0; m_got = 0; m_inflight = 0;
    end
    m_dq = Rinv_Mat_DnLoad;
  endtask

  task automatic compare_all();
    check("Rinv_Read", 32'(Rinv_Read), 32'(m_mode == 1 && !pause && m_issued < 9));
    check("mat_valid", 32'(mat_valid), 32'(m_mode == 2));
    check("Rinv_00", {16'h0, Rinv_00}, {16'h0, m_out[0]});
    check("Rinv_01", {16'h0, Rinv_01}, {16'h0, m_out[1]});
    check("Rinv_02", {16'h0, Rinv_02}, {16'h0, m_out[2]});
    check("Rinv_11", {16'h0, Rinv_11}, {16'h0, m_out[4]});
    check("Rinv_12", {16'h0, Rinv_12}, {16'h0, m_out[5]});
    check("Rinv_22", {16'h0, Rinv_22}, {16'h0, m_out[8]});
    check("struct_err", 32'(struct_err), 32'(m_serr));
    check("seq_err", 32'(seq_err), 32'(m_qerr));
    check("ovr_err", 32'(ovr_err), 32'(m_oerr));
  endtask

  // One clock: advance model, drive producer and inputs, compare at negedge.
  task automatic tick(input bit st, input bit dn, input bit ps, input bit rdy, input bit rn);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    if (prev_rd) begin
      if (rnd_mode) begin
        R_invElem = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      end else if (pidx < 9) begin
        R_invElem = stream[pidx];
        if (pidx >= fin_at) Rinv_Finish = 1'b1;
        pidx++;
      end
    end else begin
      R_invElem = 16'($urandom);
    end
    if (rnd_mode && $urandom_range(0, 15) == 0) Rinv_Finish = ~Rinv_Finish;
    start = st; Rinv_Mat_DnLoad = dn; pause = ps; mat_ready = rdy; rst_n = rn;
    if (!rn) model_reset();
    @(negedge clk);
    prev_rd = Rinv_Read;
    compare_all();
  endtask

  task automatic set_base();
    stream[0] = 16'h1000; stream[1] = 16'hF800; stream[2] = 16'h0400;
    stream[3] = 16'h0000; stream[4] = 16'h0800; stream[5] = 16'hFC00;
    stream[6] = 16'h0000; stream[7] = 16'h0000; stream[8] = 16'h2000;
  endtask

  // Start pulse, then a DnLoad rise at cycle 0; runs until mat_valid (bounded).
  task automatic do_matrix(input int fa, input int plo, input int phi);
    Rinv_Finish = 1'b0;
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    pidx = 0; fin_at = fa;
    r_nrd = 0; r_first = -1; r_last = -1; r_vc = -1; r_rdp = 0; r_s10 = -1;
    for (int c = 0; c < 40 && r_vc < 0; c++) begin
      tick(0, 1, (c >= plo && c <= phi), 0, 1);
      if (Rinv_Read) begin
        r_nrd++;
        if (r_first < 0) r_first = c;
        r_last = c;
        if (c >= plo && c <= phi) r_rdp++;
      end
      if (c == 10) r_s10 = int'(seq_err);
      if (mat_valid) r_vc = c;
    end
  endtask

  task automatic accept();
    tick(0, 1, 0, 1, 1);
    tick(0, 1, 0, 0, 1);
    check("valid_drop", 32'(mat_valid), 32'h0);
  endtask

  task automatic check_base_elems(input string tag);
    check({tag, "_00"}, {16'h0, Rinv_00}, 32'h1000);
    check({tag, "_01"}, {16'h0, Rinv_01}, 32'hF800);
    check({tag, "_02"}, {16'h0, Rinv_02}, 32'h0400);
    check({tag, "_11"}, {16'h0, Rinv_11}, 32'h0800);
    check({tag, "_12"}, {16'h0, Rinv_12}, 32'hFC00);
    check({tag, "_22"}, {16'h0, Rinv_22}, 32'h2000);
  endtask

  initial begin
    int rdcnt;
    bit dn;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; Rinv_Mat_DnLoad = 1'b0; Rinv_Finish = 1'b0;
    R_invElem = '0; pause = 1'b0; mat_ready = 1'b0;
    prev_rd = 0; rnd_mode = 0; pidx = 0; fin_at = 8;
    set_base();
    model_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("rst_read", 32'(Rinv_Read), 32'h0);
    check("rst_valid", 32'(mat_valid), 32'h0);
    check("rst_e00", {16'h0, Rinv_00}, 32'h0);
    check("rst_errs", {29'h0, struct_err, seq_err, ovr_err}, 32'h0);
    tick(0, 0, 0, 0, 1);

    // Plain stream, Finish on the 9th element
    do_matrix(8, -1, -1);
    check("s1_nrd", r_nrd, 9);
    check("s1_first", r_first, 1);
    check("s1_last", r_last, 9);
    check("s1_valid_cyc", r_vc, 11);
    check_base_elems("s1");
    check("s1_errs", {29'h0, struct_err, seq_err, ovr_err}, 32'h0);
    accept();

    // Pause in cycles 3..5
    do_matrix(8, 3, 5);
    check("s2_nrd", r_nrd, 9);
    check("s2_rd_in_pause", r_rdp, 0);
    check("s2_last", r_last, 12);
    check("s2_valid_cyc", r_vc, 14);
    check_base_elems("s2");
    check("s2_errs", {29'h0, struct_err, seq_err, ovr_err}, 32'h0);
    accept();

    // Nonzero lower-triangle slot 6
    stream[6] = 16'h0001;
    do_matrix(8, -1, -1);
    check("s3_valid_cyc", r_vc, 11);
    check("s3_struct", 32'(struct_err), 32'h1);
    check_base_elems("s3");
    accept();
    set_base();
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    check("s3_struct_clr", 32'(struct_err), 32'h0);

    // Finish early (5th element), then Finish never
    do_matrix(4, -1, -1);
    check("s4a_seq_c10", r_s10, 1);
    check("s4a_seq", 32'(seq_err), 32'h1);
    accept();
    do_matrix(9, -1, -1);
    check("s4b_seq_c10", r_s10, 0);
    check("s4b_seq", 32'(seq_err), 32'h1);
    check("s4b_valid_cyc", r_vc, 11);
    accept();

    // Overrun while held
    do_matrix(8, -1, -1);
    rdcnt = 0;
    tick(0, 0, 0, 0, 1); rdcnt += int'(Rinv_Read);
    tick(0, 1, 0, 0, 1); rdcnt += int'(Rinv_Read);
    tick(0, 1, 0, 0, 1); rdcnt += int'(Rinv_Read);
    check("s5_ovr", 32'(ovr_err), 32'h1);
    check("s5_valid_held", 32'(mat_valid), 32'h1);
    tick(0, 1, 0, 1, 1); rdcnt += int'(Rinv_Read);
    tick(0, 1, 0, 0, 1); rdcnt += int'(Rinv_Read);
    check("s5_valid_drop", 32'(mat_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0, 1); rdcnt += int'(Rinv_Read);
    end
    check("s5_no_read", rdcnt, 0);

    // Reset in cycle 6 of a read
    tick(0, 0, 0, 0, 1);
    Rinv_Finish = 1'b0; pidx = 0; fin_at = 8;
    for (int c = 0; c < 6; c++) tick(0, 1, 0, 0, 1);
    check("s6_ovr_before", 32'(ovr_err), 32'h1);
    tick(0, 0, 0, 0, 0);
    check("s6_rst_read", 32'(Rinv_Read), 32'h0);
    check("s6_rst_e00", {16'h0, Rinv_00}, 32'h0);
    check("s6_rst_e22", {16'h0, Rinv_22}, 32'h0);
    check("s6_rst_errs", {29'h0, struct_err, seq_err, ovr_err}, 32'h0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    do_matrix(8, -1, -1);
    check("s6_valid_cyc", r_vc, 11);
    check_base_elems("s6");
    accept();

    // Random traffic against the model
    rnd_mode = 1;
    dn = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) dn = ~dn;
      tick($urandom_range(0, 59) == 0, dn, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 249) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rinv_collector.md
Name: rinv_collector

Overview:
- Reader end of the R-inverse element stream.
- Detects the producer's matrix-ready flag, drives the read strobe, and captures the 9 row-major Q4.12 elements that arrive one cycle after each read.
- Checks that the lower triangle is zero and that the finish flag is timed correctly.
- Presents the six upper-triangular elements in parallel to the downstream multiply stage through a valid/ready handshake.

Parameters:
SIZE, 16, element width (signed Q4.12)
N_ELEM, 9, elements per matrix (3x3, row-major); fixed, not for override

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  synchronous abort/clear; same pulse that launches a new inversion
Rinv_Mat_DnLoad  input  1  producer matrix loaded; level, stays high until next calc
Rinv_Finish  input  1  producer finished streaming; level
R_invElem  input  SIZE  streamed element, valid the cycle after each read cycle
pause  input  1  downstream throttle; suppresses Rinv_Read while high
Rinv_Read  output  1  read strobe to producer, one element per high cycle
Rinv_00, Rinv_01, Rinv_02, Rinv_11, Rinv_12, Rinv_22  output  SIZE each  captured upper-triangle elements
mat_valid  output  1  captured matrix available
mat_ready  input  1  downstream accepts matrix
struct_err  output  1  sticky: lower-triangle element nonzero
seq_err  output  1  sticky: Rinv_Finish early or missing
ovr_err  output  1  sticky: new DnLoad rising edge while mat_valid held

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0; req_cnt, cap_cnt, rd_q and dnload_q cleared.
  - Reset mid-read abandons the partial matrix.
- dnload_q registers Rinv_Mat_DnLoad each cycle. rise = Rinv_Mat_DnLoad & ~dnload_q.
- start high (any state, highest priority after reset):
  - next state IDLE; counters cleared; mat_valid 0; all error flags cleared.
  - Element outputs hold their value.
- IDLE:
  - Rinv_Read = 0.
  - On rise: go to READ with req_cnt = 0 and cap_cnt = 0.
- READ:
  - Rinv_Read = ~pause & (req_cnt < 9), combinational.
  - req_cnt increments on each cycle Rinv_Read is high.
  - rd_q <= Rinv_Read.
  - On each cycle with rd_q = 1: capture R_invElem into slot cap_cnt, then increment cap_cnt.
  - Slots 0, 1, 2, 4, 5, 8 map to Rinv_00, 01, 02, 11, 12, 22.
  - Slots 3, 6, 7 are not stored; if nonzero, set struct_err.
  - During captures 0–7, Rinv_Finish = 1 sets seq_err.
  - During capture 8, Rinv_Finish is sampled; 0 sets seq_err. After capture 8, go to HOLD.
  - pause mid-stream freezes req_cnt. The in-flight element (rd_q = 1) is still captured the following cycle. Stream resumes with no loss or duplication.
- HOLD:
  - mat_valid = 1; element outputs stable; Rinv_Read = 0.
  - mat_valid & mat_ready: clear mat_valid, go to IDLE.
  - rise while in HOLD: set ovr_err; the edge is dropped, no new read.
  - rise and mat_ready in the same cycle: accept the handshake, go to IDLE, and set ovr_err. The edge is not re-armed.
- Latency with pause = 0:
  - rise observed in cycle 0.
  - Rinv_Read high in cycles 1–9.
  - Captures at the ends of cycles 2–10.
  - mat_valid high from cycle 11.
- No arithmetic on elements: bits are passed through unmodified, including sign.
- Error flags are sticky until start or reset and do not block the state machine.

Test Plan:
1. Reset, then DnLoad rise with producer stream 0x1000, 0xF800, 0x0400, 0, 0x0800, 0xFC00, 0, 0, 0x2000 and Finish at the 9th element, pause = 0 -> Rinv_Read high for exactly 9 cycles (1–9); mat_valid at cycle 11; Rinv_00 = 0x1000, 01 = 0xF800, 02 = 0x0400, 11 = 0x0800, 12 = 0xFC00, 22 = 0x2000; no errors.
2. Same stream with pause high in cycles 3–5 -> Rinv_Read low in those cycles; all 9 elements captured once; values identical to scenario 1; mat_valid at cycle 14.
3. Slot 6 = 0x0001 -> struct_err = 1, matrix still delivered; start pulse clears struct_err to 0.
4. Finish asserted at the 5th element -> seq_err = 1. Separately, Finish never asserted -> seq_err set on capture 8.
5. Hold mat_ready low and toggle DnLoad low then high -> ovr_err = 1, no Rinv_Read; mat_ready high -> mat_valid drops next cycle, state IDLE.
6. Assert rst_n low at cycle 6 of a read -> all outputs 0 immediately. After release, a fresh DnLoad rise yields a complete correct matrix.
